// File: rtl/writeback_stage_if.sv
// writeback_stage_if: M-stage inputs into the MEM/WB register and W-stage writeback outputs.
// Ports:
//   M side (master drives): ValidM, FlushW, RegwriteM, ResultsrcM, SignExMM, MuxsignM,
//                           ALUResultM, ReadDataM, PCplus4M, Immediate_valueM, PCTargetM, RDM
//   W side (slave drives):  Write_EnaW, Write_DataW, Write_addrW, ValidW,
//                           instret (only with WB_INSTRET_EN)
interface writeback_stage_if #(parameter int INSTRET_W = 64);
    logic        ValidM;
    logic        FlushW;
    logic        RegwriteM;
    logic [2:0]  ResultsrcM;
    logic [1:0]  SignExMM;
    logic        MuxsignM;
    logic [31:0] ALUResultM;
    logic [31:0] ReadDataM;
    logic [31:0] PCplus4M;
    logic [31:0] Immediate_valueM;
    logic [31:0] PCTargetM;
    logic [4:0]  RDM;
    logic        Write_EnaW;
    logic [31:0] Write_DataW;
    logic [4:0]  Write_addrW;
    logic        ValidW;
`ifdef WB_INSTRET_EN
    logic [INSTRET_W-1:0] instret;
`endif
    modport master (
        output ValidM, FlushW, RegwriteM, ResultsrcM, SignExMM, MuxsignM,
               ALUResultM, ReadDataM, PCplus4M, Immediate_valueM, PCTargetM, RDM,
`ifdef WB_INSTRET_EN
        input  instret,
`endif
        input  Write_EnaW, Write_DataW, Write_addrW, ValidW
    );
    modport slave (
        input  ValidM, FlushW, RegwriteM, ResultsrcM, SignExMM, MuxsignM,
               ALUResultM, ReadDataM, PCplus4M, Immediate_valueM, PCTargetM, RDM,
`ifdef WB_INSTRET_EN
        output instret,
`endif
        output Write_EnaW, Write_DataW, Write_addrW, ValidW
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, load formatting, result select and register-file write port.
// Ports: clk, rst (sync, active-high); bus (writeback_stage_if.slave) carrying M-stage inputs
// and W-stage outputs. Optional retired-instruction counter enabled by macro WB_INSTRET_EN.
module writeback_stage #(
    parameter int INSTRET_W = 64
) (
    input logic             clk,
    input logic             rst,
    writeback_stage_if.slave bus
);
    logic        valid_w;
    logic        regwrite_w;
    logic [2:0]  resultsrc_w;
    logic [1:0]  signex_w;
    logic        muxsign_w;
    logic [31:0] alu_w;
    logic [31:0] read_data_w;
    logic [31:0] pc4_w;
    logic [31:0] imm_w;
    logic [31:0] pc_target_w;
    logic [4:0]  rd_w;
    logic [1:0]  off_w;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] result;

    // A killed or bubble slot keeps its data fields but can never write or retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_w     <= 1'b0;
            regwrite_w  <= 1'b0;
            resultsrc_w <= '0;
            signex_w    <= '0;
            muxsign_w   <= 1'b0;
            alu_w       <= '0;
            read_data_w <= '0;
            pc4_w       <= '0;
            imm_w       <= '0;
            pc_target_w <= '0;
            rd_w        <= '0;
            off_w       <= '0;
        end else begin
            valid_w     <= bus.ValidM & ~bus.FlushW;
            regwrite_w  <= bus.RegwriteM & bus.ValidM & ~bus.FlushW;
            resultsrc_w <= bus.ResultsrcM;
            signex_w    <= bus.SignExMM;
            muxsign_w   <= bus.MuxsignM;
            alu_w       <= bus.ALUResultM;
            read_data_w <= bus.ReadDataM;
            pc4_w       <= bus.PCplus4M;
            imm_w       <= bus.Immediate_valueM;
            pc_target_w <= bus.PCTargetM;
            rd_w        <= bus.RDM;
            off_w       <= bus.ALUResultM[1:0];
        end
    end

    always_comb begin
        byte_sel  = read_data_w[8*off_w +: 8];
        half_sel  = off_w[1] ? read_data_w[31:16] : read_data_w[15:0];
        load_data = (signex_w == 2'b10) ? {{24{~muxsign_w & byte_sel[7]}}, byte_sel} :
                    (signex_w == 2'b01) ? {{16{~muxsign_w & half_sel[15]}}, half_sel} :
                    read_data_w;
        result    = (resultsrc_w == 3'b000) ? alu_w :
                    (resultsrc_w == 3'b001) ? load_data :
                    (resultsrc_w == 3'b010) ? pc4_w :
                    (resultsrc_w == 3'b011) ? imm_w :
                    (resultsrc_w == 3'b100) ? pc_target_w : 32'h0;
    end

    assign bus.Write_DataW = result;
    assign bus.Write_addrW = rd_w;
    assign bus.Write_EnaW  = regwrite_w & valid_w & (rd_w != 5'd0);
    assign bus.ValidW      = valid_w;

`ifdef WB_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q;

    // Counts every retirement, including x0 and non-writing instructions; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)
            instret_q <= '0;
        else if (valid_w)
            instret_q <= instret_q + 1'b1;
    end

    assign bus.instret = instret_q;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int cnt_model = 0;
    bit prev_valid = 0;

    typedef struct {
        bit        valid, flush, rw, ms;
        bit [2:0]  rs;
        bit [1:0]  sx;
        bit [31:0] alu, rdat, pc4, imm, pct;
        bit [4:0]  rd;
    } stim_t;

    always #5 clk = ~clk;

    writeback_stage_if #(.INSTRET_W(64)) bus ();
    writeback_stage #(.INSTRET_W(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic stim_t mk(bit [2:0] rs, bit [1:0] sx, bit ms, bit [31:0] alu,
                                 bit [31:0] rdat, bit [4:0] rd);
        stim_t s;
        s = '{valid: 1, flush: 0, rw: 1, ms: ms, rs: rs, sx: sx, alu: alu, rdat: rdat,
              pc4: 32'h104, imm: 32'hABCDE000, pct: 32'h2000, rd: rd};
        return s;
    endfunction

    function automatic bit [31:0] load_val(stim_t s);
        longint unsigned f, w;
        int off;
        off = int'(s.alu % 4);
        if (s.sx == 2) begin
            f = (longint'(s.rdat) >> (8 * off)) % 256;
            w = 8;
        end else if (s.sx == 1) begin
            f = (longint'(s.rdat) >> (off >= 2 ? 16 : 0)) % 65536;
            w = 16;
        end else
            return s.rdat;
        if (!s.ms && f >= (64'd1 << (w - 1)))
            f = f + (64'd1 << 32) - (64'd1 << w);
        return f[31:0];
    endfunction

    function automatic bit [31:0] exp_data(stim_t s);
        case (s.rs)
            3'd0: return s.alu;
            3'd1: return load_val(s);
            3'd2: return s.pc4;
            3'd3: return s.imm;
            3'd4: return s.pct;
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input stim_t s, input bit r, input string tag);
        bit ev;
        rst = r;
        bus.ValidM = s.valid; bus.FlushW = s.flush; bus.RegwriteM = s.rw;
        bus.ResultsrcM = s.rs; bus.SignExMM = s.sx; bus.MuxsignM = s.ms;
        bus.ALUResultM = s.alu; bus.ReadDataM = s.rdat; bus.PCplus4M = s.pc4;
        bus.Immediate_valueM = s.imm; bus.PCTargetM = s.pct; bus.RDM = s.rd;
        @(posedge clk);
        #1;
        cnt_model = r ? 0 : cnt_model + (prev_valid ? 1 : 0);
        ev = !r && s.valid && !s.flush;
        prev_valid = ev;
        check({tag, "_valid"}, 64'(bus.ValidW), 64'(ev));
        check({tag, "_en"}, 64'(bus.Write_EnaW), 64'(ev && s.rw && s.rd != 0));
        if (r) begin
            check({tag, "_data"}, 64'(bus.Write_DataW), 64'h0);
            check({tag, "_addr"}, 64'(bus.Write_addrW), 64'h0);
        end else if (ev) begin
            check({tag, "_data"}, 64'(bus.Write_DataW), 64'(exp_data(s)));
            check({tag, "_addr"}, 64'(bus.Write_addrW), 64'(s.rd));
        end
`ifdef WB_INSTRET_EN
        check({tag, "_instret"}, bus.instret, 64'(cnt_model));
`endif
    endtask

    initial begin
        stim_t s;
        s = mk(3'd0, 2'd0, 0, 32'h55, 32'h0, 5'd5);
        step(s, 1, "rst0");
        step(s, 1, "rst1");
        step(mk(3'd0, 2'd0, 0, 32'h77, 32'h0, 5'd4), 0, "first");
        step(mk(3'd1, 2'b10, 0, 32'h2, 32'h80FF7F01, 5'd7), 0, "lb_s");
        step(mk(3'd1, 2'b10, 1, 32'h2, 32'h80FF7F01, 5'd7), 0, "lb_u");
        step(mk(3'd1, 2'b01, 0, 32'h2, 32'h80011234, 5'd8), 0, "lh_s2");
        step(mk(3'd1, 2'b01, 1, 32'h2, 32'h80011234, 5'd8), 0, "lh_u2");
        step(mk(3'd1, 2'b01, 0, 32'h0, 32'h80011234, 5'd8), 0, "lh_s0");
        step(mk(3'd1, 2'b00, 0, 32'h3, 32'h80011234, 5'd9), 0, "lw");
        step(mk(3'd0, 2'd0, 0, 32'h11, 32'h0, 5'd10), 0, "mux0");
        step(mk(3'd2, 2'd0, 0, 32'h11, 32'h0, 5'd10), 0, "mux2");
        step(mk(3'd3, 2'd0, 0, 32'h11, 32'h0, 5'd10), 0, "mux3");
        step(mk(3'd4, 2'd0, 0, 32'h11, 32'h0, 5'd10), 0, "mux4");
        step(mk(3'd7, 2'd0, 0, 32'h11, 32'h0, 5'd10), 0, "mux7");
        step(mk(3'd0, 2'd0, 0, 32'h11, 32'h0, 5'd0), 0, "x0");
        s = mk(3'd0, 2'd0, 0, 32'h11, 32'h0, 5'd3); s.flush = 1;
        step(s, 0, "flush");
        s = mk(3'd0, 2'd0, 0, 32'h11, 32'h0, 5'd3); s.valid = 0;
        step(s, 0, "bubble");
        step(mk(3'd0, 2'd0, 0, 32'h12, 32'h0, 5'd3), 0, "after_bubble");
        step(mk(3'd0, 2'd0, 0, 32'h0, 32'h0, 5'd0), 1, "cnt_rst");
        for (int i = 0; i < 15; i++) begin
            s = mk(3'd0, 2'd0, 0, 32'(i), 32'h0, 5'(i + 1));
            if (i >= 10 && i < 12) s.flush = 1;
            if (i >= 12) s.valid = 0;
            step(s, 0, "cnt");
        end
`ifdef WB_INSTRET_EN
        check("instret_10", bus.instret, 64'd10);
`endif
        for (int i = 0; i < 400; i++) begin
            s.valid = 1'($urandom_range(0, 3) != 0);
            s.flush = 1'($urandom_range(0, 7) == 0);
            s.rw = 1'($urandom);
            s.ms = 1'($urandom);
            s.rs = 3'($urandom);
            s.sx = 2'($urandom);
            s.alu = $urandom; s.rdat = $urandom; s.pc4 = $urandom;
            s.imm = $urandom; s.pct = $urandom; s.rd = 5'($urandom);
            step(s, $urandom_range(0, 24) == 0, "rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
